pc_fetch_unit: RTL and testbench

Parametrised program-counter and fetch-address generator for the RISC-V core's instruction-fetch stage.
- Supports absolute, PC-relative and return redirects, in addition to sequential advance and hold.
- Contains an internal return-address stack (RAS) and a valid/ready handshake towards instruction memory.
- Sits between the branch/jump resolution logic and the instruction memory address port.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_fetch_unit_if.sv | 34 +++
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_fetch_unit.sv | 93 +++++++++
 tb/tb_pc_fetch_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the instruction-fetch PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_ABS  = 2'd0,
    PC_REL  = 2'd1,
    PC_RET  = 2'd2,
    PC_RSVD = 2'd3
  } pc_mode_e;

  localparam int unsigned PC_DEFAULT_INST_BYTES   = 4;
  localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = '0;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Redirect, RAS-push and fetch-handshake signals between the core and the PC unit.
interface pc_fetch_unit_if
  import pc_pkg::*;
#(
  parameter int unsigned AW = 32
);

  logic          pc_hold;
  logic          redirect_valid;
  pc_mode_e      redirect_mode;
  logic [AW-1:0] redirect_target;
  logic          ras_push;
  logic [AW-1:0] ras_push_addr;
  logic          fetch_ready;
  logic [AW-1:0] inst_addr;
  logic          fetch_valid;
  logic          ras_empty;
  logic          ras_full;
  logic          misalign_err;
  logic          ras_underflow;

  modport master (
    output pc_hold, redirect_valid, redirect_mode, redirect_target,
    output ras_push, ras_push_addr, fetch_ready,
    input  inst_addr, fetch_valid, ras_empty, ras_full, misalign_err, ras_underflow
  );

  modport slave (
    input  pc_hold, redirect_valid, redirect_mode, redirect_target,
    input  ras_push, ras_push_addr, fetch_ready,
    output inst_addr, fetch_valid, ras_empty, ras_full, misalign_err, ras_underflow
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign top   = mem_q[top_q];

  always_comb begin
    mem_d  = mem_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    do_pop = pop && !empty;
    // Push+pop reuses the slot just vacated, so pointer and count stay put;
    // a pop on an empty stack is ignored, leaving a plain push.
    if (do_pop && push) begin
      mem_d[top_q] = push_addr;
    end else if (do_pop) begin
      top_d = ptr_dec(top_q);
      cnt_d = cnt_q - CW'(1);
    end else if (push) begin
      top_d        = ptr_inc(top_q);
      mem_d[top_d] = push_addr;
      if (!full) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-address generator: redirect mux, alignment check,
// sticky error flags and the valid/ready advance towards instruction memory.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned INST_MEMORY_ADDRESS_WIDTH = 32,
  parameter logic [INST_MEMORY_ADDRESS_WIDTH-1:0] RESET_VECTOR =
    INST_MEMORY_ADDRESS_WIDTH'(PC_DEFAULT_RESET_VECTOR),
  parameter int unsigned INST_BYTES = PC_DEFAULT_INST_BYTES,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.slave  bus
);

  localparam int unsigned AW = INST_MEMORY_ADDRESS_WIDTH;
  localparam logic [AW-1:0] STEP       = AW'(INST_BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(INST_BYTES - 1);

  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          mis_q, mis_d;
  logic          und_q, und_d;
  logic [AW-1:0] cand;
  logic          ras_pop;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_full;

  pc_ras #(
    .WIDTH (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ras_push),
    .push_addr (bus.ras_push_addr),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
    mis_d   = mis_q;
    und_d   = und_q;
    ras_pop = 1'b0;
    cand    = '0;
    if (bus.redirect_valid && bus.redirect_mode != PC_RSVD) begin
      if (bus.redirect_mode == PC_RET) begin
        ras_pop = 1'b1;
        if (!ras_empty) begin
          pc_d = ras_top;
        end else begin
          pc_d  = pc_q + STEP;
          und_d = 1'b1;
        end
      end else begin
        cand = (bus.redirect_mode == PC_ABS) ? bus.redirect_target
                                             : pc_q + bus.redirect_target;
        if ((cand & ALIGN_MASK) != '0) mis_d = 1'b1;
        pc_d = cand & ~ALIGN_MASK;
      end
    end else if (!bus.pc_hold && valid_q && bus.fetch_ready) begin
      pc_d = pc_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      und_q   <= und_d;
    end
  end

  assign bus.inst_addr     = pc_q;
  assign bus.fetch_valid   = valid_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.misalign_err  = mis_q;
  assign bus.ras_underflow = und_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a queue-based reference model.
module tb_pc_fetch_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.AW(32)) bus ();

  pc_fetch_unit #(
    .INST_MEMORY_ADDRESS_WIDTH (32),
    .RESET_VECTOR              (32'h0),
    .INST_BYTES                (4),
    .RAS_DEPTH                 (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic        m_valid, m_mis, m_und;
  logic [31:0] m_ras [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] n, t;
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_und = 1'b0;
      m_ras.delete();
      return;
    end
    n = m_pc;
    if (bus.redirect_valid && bus.redirect_mode != PC_RSVD) begin
      if (bus.redirect_mode == PC_RET) begin
        if (m_ras.size() > 0) n = m_ras.pop_back();
        else begin n = m_pc + 32'd4; m_und = 1'b1; end
      end else begin
        t = (bus.redirect_mode == PC_ABS) ? bus.redirect_target : m_pc + bus.redirect_target;
        if (t % 4 != 0) begin m_mis = 1'b1; t = t - (t % 4); end
        n = t;
      end
    end else if (!bus.pc_hold && m_valid && bus.fetch_ready) begin
      n = m_pc + 32'd4;
    end
    if (bus.ras_push) begin
      m_ras.push_back(bus.ras_push_addr);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    m_pc = n;
    m_valid = 1'b1;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check({tag, ".addr"},  bus.inst_addr,     m_pc);
    check({tag, ".valid"}, bus.fetch_valid,   m_valid);
    check({tag, ".empty"}, bus.ras_empty,     m_ras.size() == 0);
    check({tag, ".full"},  bus.ras_full,      m_ras.size() == 4);
    check({tag, ".mis"},   bus.misalign_err,  m_mis);
    check({tag, ".und"},   bus.ras_underflow, m_und);
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.pc_hold = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_mode = PC_ABS;
    bus.redirect_target = '0;
    bus.ras_push = 1'b0;
    bus.ras_push_addr = '0;
    bus.fetch_ready = 1'b0;
  endtask

  task automatic redir(input pc_mode_e mode, input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_mode = mode;
    bus.redirect_target = tgt;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    step("rst");
    rst = 1'b0;
  endtask

  initial begin
    m_pc = '0; m_valid = 1'b0; m_mis = 1'b0; m_und = 1'b0;

    // reset and sequential fetch
    idle(); rst = 1'b1;
    step("rst0"); step("rst1");
    check("rst.addr", bus.inst_addr, 32'h0);
    check("rst.valid", bus.fetch_valid, 32'h0);
    check("rst.empty", bus.ras_empty, 32'h1);
    rst = 1'b0; bus.fetch_ready = 1'b1;
    step("seq0"); check("seq0.pc", bus.inst_addr, 32'h0); check("seq0.v", bus.fetch_valid, 32'h1);
    step("seq1"); check("seq1.pc", bus.inst_addr, 32'h4);
    step("seq2"); check("seq2.pc", bus.inst_addr, 32'h8);

    // backpressure then hold
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin step("bp"); check("bp.pc", bus.inst_addr, 32'h8); end
    bus.fetch_ready = 1'b1; bus.pc_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin step("hold"); check("hold.pc", bus.inst_addr, 32'h8); end
    bus.pc_hold = 1'b0;
    step("rel"); check("release.pc", bus.inst_addr, 32'hC);

    // reserved mode under hold behaves as no redirect
    bus.pc_hold = 1'b1; redir(PC_RSVD, 32'h400);
    step("rsvd"); check("rsvd.pc", bus.inst_addr, 32'hC);
    idle();

    // relative redirects with wrap-around
    redir(PC_ABS, 32'h100); step("abs100");
    redir(PC_REL, 32'hFFFF_FFF0); step("relneg"); check("relneg.pc", bus.inst_addr, 32'hF0);
    redir(PC_ABS, 32'hFFFF_FFFC); step("absff");
    redir(PC_REL, 32'h8); step("relwrap");
    check("relwrap.pc", bus.inst_addr, 32'h4);
    check("relwrap.mis", bus.misalign_err, 32'h0);

    // redirect beats hold, misaligned target, sticky flag
    idle(); bus.pc_hold = 1'b1; redir(PC_ABS, 32'h1002);
    step("mis"); check("mis.pc", bus.inst_addr, 32'h1000); check("mis.flag", bus.misalign_err, 32'h1);
    idle(); bus.fetch_ready = 1'b1;
    for (int i = 0; i < 10; i++) step("sticky");
    check("sticky.flag", bus.misalign_err, 32'h1);
    do_reset(); check("misclr", bus.misalign_err, 32'h0);

    // RAS overflow then underflow
    for (int i = 1; i <= 5; i++) begin
      bus.ras_push = 1'b1; bus.ras_push_addr = 32'(i * 16);
      step("push");
    end
    check("ovf.full", bus.ras_full, 32'h1);
    bus.ras_push = 1'b0;
    for (int i = 5; i >= 2; i--) begin
      redir(PC_RET, 32'h0); step("ret");
      check("ret.pc", bus.inst_addr, 32'(i * 16));
    end
    check("ret.empty", bus.ras_empty, 32'h1);
    step("ret5"); check("ret5.pc", bus.inst_addr, 32'h24); check("ret5.und", bus.ras_underflow, 32'h1);

    // simultaneous push and pop
    do_reset();
    bus.ras_push = 1'b1; bus.ras_push_addr = 32'h10; step("sp0");
    bus.ras_push_addr = 32'h20; step("sp1");
    redir(PC_RET, 32'h0); bus.ras_push_addr = 32'h80; step("sp2");
    check("sp2.pc", bus.inst_addr, 32'h20);
    bus.ras_push = 1'b0;
    step("sp3"); check("sp3.pc", bus.inst_addr, 32'h80);
    step("sp4"); check("sp4.pc", bus.inst_addr, 32'h10); check("sp4.empty", bus.ras_empty, 32'h1);
    idle();
    step("sp5");

    // push+pop on empty stack
    redir(PC_RET, 32'h0); bus.ras_push = 1'b1; bus.ras_push_addr = 32'h300;
    step("epp"); check("epp.und", bus.ras_underflow, 32'h1); check("epp.empty", bus.ras_empty, 32'h0);
    idle(); redir(PC_RET, 32'h0);
    step("epp2"); check("epp2.pc", bus.inst_addr, 32'h300);
    idle();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.pc_hold = ($urandom_range(0, 3) == 0);
      bus.fetch_ready = $urandom_range(0, 1) == 1;
      bus.redirect_valid = ($urandom_range(0, 2) == 0);
      bus.redirect_mode = pc_mode_e'($urandom_range(0, 3));
      bus.redirect_target = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                                        : 32'($urandom_range(0, 64) * 4);
      bus.ras_push = ($urandom_range(0, 2) == 0);
      bus.ras_push_addr = 32'($urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
